// File: rtl/cacheline_adapter.sv
// Collects four in-order 64-bit read beats into one 256-bit cache line.
// The line address is captured with beat 0, and ready pulses for one cycle after beat 3.
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  raddr,
    input  logic [63:0]  rdata,
    input  logic         rvalid,
    output logic         ready,
    output logic [31:0]  addr,
    output logic [255:0] cacheline_data
);

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        BEAT3 = 2'd3
    } beat_t;

    beat_t       r_beat;
    beat_t       w_beat_next;
    logic        r_ready;
    logic        w_ready_next;
    logic [31:0] r_addr;
    logic [1:0]  w_beat_idx;
    logic [3:0]  w_slot_we;
    logic [63:0] r_slot [4];
    logic        w_unused_raddr_lsbs;

    // The line address is 32-byte aligned, so the low address bits are never used.
    assign w_unused_raddr_lsbs = ^raddr[4:0];
    assign w_beat_idx          = r_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat  <= BEAT0;
            r_ready <= 1'b0;
        end else begin
            r_beat  <= w_beat_next;
            r_ready <= w_ready_next;
        end
    end

    always_comb begin
        w_beat_next  = r_beat;
        w_ready_next = 1'b0;
        if (rvalid) begin
            w_ready_next = (r_beat == BEAT3);
            case (r_beat)
                BEAT0:   w_beat_next = BEAT1;
                BEAT1:   w_beat_next = BEAT2;
                BEAT2:   w_beat_next = BEAT3;
                BEAT3:   w_beat_next = BEAT0;
                default: w_beat_next = BEAT0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= 32'd0;
        end else if (rvalid && (r_beat == BEAT0)) begin
            r_addr <= {raddr[31:5], 5'b0};
        end
    end

    // Each slot loads only on its own beat; slots not touched by a burst keep stale data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign w_slot_we[gi] = rvalid && (w_beat_idx == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot[gi] <= 64'd0;
                end else if (w_slot_we[gi]) begin
                    r_slot[gi] <= rdata;
                end
            end

            assign cacheline_data[64*gi +: 64] = r_slot[gi];
        end
    endgenerate

    assign ready = r_ready;
    assign addr  = r_addr;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed scenarios plus randomized traffic,
// compared every cycle against a beat-level reference model of the line assembler.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  raddr;
    logic [63:0]  rdata;
    logic         rvalid;
    logic         ready;
    logic [31:0]  addr;
    logic [255:0] cacheline_data;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Reference model state
    logic [63:0]  m_line [4];
    int           m_cnt;
    logic [31:0]  m_addr;
    logic         m_ready;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .raddr          (raddr),
        .rdata          (rdata),
        .rvalid         (rvalid),
        .ready          (ready),
        .addr           (addr),
        .cacheline_data (cacheline_data)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_line();
        logic [255:0] l;
        l = {m_line[3], m_line[2], m_line[1], m_line[0]};
        return l;
    endfunction

    // One clock cycle: drive at negedge, update model at posedge, check just after.
    task automatic cyc(input logic r, input logic v, input logic [63:0] d, input logic [31:0] a);
        @(negedge clk);
        rst    = r;
        rvalid = v;
        rdata  = v ? d : 64'bx;
        raddr  = v ? a : 32'bx;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) m_line[i] = 64'd0;
            m_cnt   = 0;
            m_addr  = 32'd0;
            m_ready = 1'b0;
        end else begin
            m_ready = v && (m_cnt == 3);
            if (v) begin
                if (m_cnt == 0) m_addr = a & 32'hFFFF_FFE0;
                m_line[m_cnt] = d;
                m_cnt = (m_cnt + 1) % 4;
            end
        end
        #1;
        chk("ready", {255'd0, ready}, {255'd0, m_ready});
        chk("addr", {224'd0, addr}, {224'd0, m_addr});
        chk("line", cacheline_data, model_line());
        if (ready) begin
            pulses++;
            $display("line done addr=%h data=%h", addr, cacheline_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 32'd0);
    endtask

    logic [63:0]  bv [8];
    logic [255:0] exp_line;
    int           p0;
    int           t_first;
    int           t_second;

    initial begin
        rst = 1'b1; rvalid = 1'b0; rdata = 'x; raddr = 'x;
        for (int i = 0; i < 4; i++) m_line[i] = 64'd0;
        m_cnt = 0; m_addr = 32'd0; m_ready = 1'b0;

        // Reset, then idle with X on data/address
        cyc(1'b1, 1'b0, 64'd0, 32'd0);
        cyc(1'b1, 1'b0, 64'd0, 32'd0);
        idle(4);
        chk("reset_line", cacheline_data, 256'd0);

        // Four consecutive beats of alternating ones/zeros at address 0
        p0 = pulses;
        cyc(1'b0, 1'b1, {64{1'b1}}, 32'd0);
        chk("beat0_slot", {192'd0, cacheline_data[63:0]}, {192'd0, {64{1'b1}}});
        cyc(1'b0, 1'b1, 64'd0, 32'd0);
        cyc(1'b0, 1'b1, {64{1'b1}}, 32'd0);
        cyc(1'b0, 1'b1, 64'd0, 32'd0);
        exp_line = 256'h0000000000000000_FFFFFFFFFFFFFFFF_0000000000000000_FFFFFFFFFFFFFFFF;
        chk("alt_line", cacheline_data, exp_line);
        chk("alt_ready", {255'd0, ready}, 256'd1);
        idle(2);
        chk("alt_pulses", 256'(pulses - p0), 256'd1);

        // Burst with 2-cycle gaps at an unaligned address
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 64'(i + 1), 32'h1234_5678);
            idle(2);
        end
        chk("gap_addr", {224'd0, addr}, {224'd0, 32'h1234_5660});
        chk("gap_line", cacheline_data, {64'h4, 64'h3, 64'h2, 64'h1});
        chk("gap_pulses", 256'(pulses - p0), 256'd1);

        // Two back-to-back bursts, no gap
        for (int i = 0; i < 8; i++) bv[i] = {$urandom, $urandom};
        t_first = -1; t_second = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, bv[i], 32'hA000_0040 + 32'(i));
            if (ready && t_first < 0) t_first = i;
            else if (ready) t_second = i;
        end
        cyc(1'b0, 1'b0, 64'd0, 32'd0);
        if (ready) t_second = 8;
        chk("b2b_spacing", 256'(t_second - t_first), 256'd4);
        chk("b2b_line2", cacheline_data, {bv[7], bv[6], bv[5], bv[4]});

        // Reset mid-burst, then a full burst
        p0 = pulses;
        cyc(1'b0, 1'b1, 64'hDEAD, 32'h0000_1000);
        cyc(1'b0, 1'b1, 64'hBEEF, 32'h0000_1000);
        cyc(1'b1, 1'b0, 64'd0, 32'd0);
        chk("midrst_line", cacheline_data, 256'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 64'(100 + i), 32'h0000_2020);
            if (i < 3) chk("midrst_noready", {255'd0, ready}, 256'd0);
        end
        chk("midrst_line2", cacheline_data, {64'd103, 64'd102, 64'd101, 64'd100});
        chk("midrst_pulses", 256'(pulses - p0), 256'd1);

        // rvalid held high while in reset
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 64'h5555, 32'hFFFF_FFFF);
        chk("rst_rvalid_line", cacheline_data, 256'd0);
        chk("rst_rvalid_addr", {224'd0, addr}, 256'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                {$urandom, $urandom}, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
